// File: rtl/card_hand_dealer.sv
// card_hand_dealer
//
// Upstream stage of the per-card 7-segment decoders in the baccarat
// datapath. A free-running 1..13 counter advances every clock, so the card
// you get depends on when the deal key is pressed. Each accepted deal
// latches the counter into the next free slot of a 3-card hand. The block
// also keeps a registered baccarat score (sum of pip values mod 10).
//
// Ports
//   clk       in   system clock, rising-edge active
//   rst       in   synchronous active-high reset (overrides deal/clear)
//   deal      in   deal request, level-sensitive: each high cycle is a request
//   clear     in   empty the hand (priority over deal)
//   card1..3  out  slot card codes, 0 = empty, 1..13 = A..K
//   count     out  occupied slots 0..3
//   full      out  count == 3
//   deal_ack  out  one-cycle pulse the cycle after an accepted deal
//   score     out  hand value mod 10
//
// Handshake: deal has no ready; a request is accepted on a rising edge
// where deal=1, clear=0, rst=0 and count<3. deal_ack=1 in exactly the
// following cycle for each accepted request; dropped requests
// (hand full, clear, reset) never produce deal_ack.
//
// All outputs are registered; no combinational input-to-output path.

module card_hand_dealer #(
  parameter int CARD_MIN = 1,
  parameter int CARD_MAX = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       deal,
  input  logic       clear,
  output logic [3:0] card1,
  output logic [3:0] card2,
  output logic [3:0] card3,
  output logic [1:0] count,
  output logic       full,
  output logic       deal_ack,
  output logic [3:0] score
);

  localparam logic [3:0] CMIN = 4'(CARD_MIN);
  localparam logic [3:0] CMAX = 4'(CARD_MAX);

  logic [3:0] counter;
  logic       accept;
  logic [4:0] raw_sum;
  logic [3:0] score_next;

  // Baccarat pip value: tens and face cards (and empty slots) count zero.
  function automatic logic [4:0] pip(input logic [3:0] c);
    return (c <= 4'd9) ? {1'b0, c} : 5'd0;
  endfunction

  assign accept = deal && !clear && (count != 2'd3);

  // Raw sum is at most 27, so one conditional subtraction of 20 or 10
  // brings it into 0..9.
  always_comb begin
    raw_sum    = pip(card1) + pip(card2) + pip(card3);
    score_next = raw_sum[3:0];
    if (raw_sum >= 5'd20)
      score_next = 4'(raw_sum - 5'd20);
    else if (raw_sum >= 5'd10)
      score_next = 4'(raw_sum - 5'd10);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter  <= CMIN;
      card1    <= 4'd0;
      card2    <= 4'd0;
      card3    <= 4'd0;
      count    <= 2'd0;
      full     <= 1'b0;
      deal_ack <= 1'b0;
      score    <= 4'd0;
    end else begin
      // Counter runs regardless of deal/clear.
      counter  <= (counter == CMAX) ? CMIN : counter + 4'd1;
      deal_ack <= accept;
      if (clear) begin
        card1 <= 4'd0;
        card2 <= 4'd0;
        card3 <= 4'd0;
        count <= 2'd0;
        full  <= 1'b0;
        score <= 4'd0;
      end else begin
        // Score follows the card registers with one cycle of latency.
        score <= score_next;
        if (accept) begin
          case (count)
            2'd0:    card1 <= counter;
            2'd1:    card2 <= counter;
            default: card3 <= counter;
          endcase
          count <= count + 2'd1;
          full  <= (count == 2'd2);
        end
      end
    end
  end

endmodule

// File: tb/tb_card_hand_dealer.sv
// Directed bench for card_hand_dealer. A small reference model tracks the
// card counter and hand occupancy; every accepted deal pushes the expected
// card code into exp_q, and each deal_ack pops and checks the slot filled.

module tb_card_hand_dealer;

  logic       clk = 1'b0;
  logic       rst;
  logic       deal;
  logic       clear;
  logic [3:0] card1, card2, card3;
  logic [1:0] count;
  logic       full;
  logic       deal_ack;
  logic [3:0] score;

  card_hand_dealer dut (
    .clk      (clk),
    .rst      (rst),
    .deal     (deal),
    .clear    (clear),
    .card1    (card1),
    .card2    (card2),
    .card3    (card3),
    .count    (count),
    .full     (full),
    .deal_ack (deal_ack),
    .score    (score)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];
  int         ref_ctr = 1;
  int         m_count = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] slot(input int idx);
    case (idx)
      1:       return card1;
      2:       return card2;
      default: return card3;
    endcase
  endfunction

  // One clock: predict acceptance from driven inputs, advance the model at
  // the edge, then check handshake/occupancy #1 after the edge.
  task automatic tick();
    logic acc;
    logic [3:0] e;
    acc = deal && !clear && !rst && (m_count < 3);
    if (acc) exp_q.push_back(4'(ref_ctr));
    @(posedge clk);
    if (rst) begin
      ref_ctr = 1;
      m_count = 0;
    end else begin
      ref_ctr = (ref_ctr == 13) ? 1 : ref_ctr + 1;
      if (clear) m_count = 0;
      else if (acc) m_count++;
    end
    #1;
    chk("deal_ack", {7'd0, deal_ack}, {7'd0, acc});
    chk("count", {6'd0, count}, 8'(m_count));
    chk("full", {7'd0, full}, {7'd0, (m_count == 3)});
    if (deal_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 8'd1, 8'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_card", {4'd0, slot(int'(count))}, {4'd0, e});
      end
    end
  endtask

  task automatic wait_ctr(input int v);
    for (int i = 0; i < 14 && ref_ctr != v; i++) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_card1", {4'd0, card1}, 8'd0);
    chk("clr_card2", {4'd0, card2}, 8'd0);
    chk("clr_card3", {4'd0, card3}, 8'd0);
    chk("clr_score", {4'd0, score}, 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    deal  = 1'b0;
    clear = 1'b0;
    tick();
    tick();
    chk("rst_card1", {4'd0, card1}, 8'd0);
    chk("rst_card2", {4'd0, card2}, 8'd0);
    chk("rst_card3", {4'd0, card3}, 8'd0);
    chk("rst_score", {4'd0, score}, 8'd0);
    rst = 1'b0;

    // Counter presents 1 in the first released cycle; deal at the 5th.
    for (int i = 0; i < 4; i++) tick();
    deal = 1'b1;
    tick();
    deal = 1'b0;
    chk("t1_card1", {4'd0, card1}, 8'd5);
    chk("t1_score_lag", {4'd0, score}, 8'd0);
    tick();
    chk("t1_score", {4'd0, score}, 8'd5);

    // Back-to-back deals across the counter wrap.
    do_clear();
    wait_ctr(12);
    deal = 1'b1;
    tick();
    tick();
    tick();
    deal = 1'b0;
    chk("t2_card1", {4'd0, card1}, 8'd12);
    chk("t2_card2", {4'd0, card2}, 8'd13);
    chk("t2_card3", {4'd0, card3}, 8'd1);
    tick();
    chk("t2_score", {4'd0, score}, 8'd1);

    // Deal while full is dropped.
    deal = 1'b1;
    tick();
    deal = 1'b0;
    tick();
    chk("t3_card1", {4'd0, card1}, 8'd12);
    chk("t3_card2", {4'd0, card2}, 8'd13);
    chk("t3_card3", {4'd0, card3}, 8'd1);
    chk("t3_score", {4'd0, score}, 8'd1);
    do_clear();

    // Clear and deal collide with one card in hand.
    deal = 1'b1;
    tick();
    clear = 1'b1;
    tick();
    deal  = 1'b0;
    clear = 1'b0;
    chk("t4_card1", {4'd0, card1}, 8'd0);
    chk("t4_score", {4'd0, score}, 8'd0);

    // Score mod 10 and face cards: 9, 8, J.
    wait_ctr(9);
    deal = 1'b1;
    tick();
    deal = 1'b0;
    tick();
    chk("t5_score9", {4'd0, score}, 8'd9);
    wait_ctr(8);
    deal = 1'b1;
    tick();
    deal = 1'b0;
    tick();
    chk("t5_score17", {4'd0, score}, 8'd7);
    wait_ctr(11);
    deal = 1'b1;
    tick();
    deal = 1'b0;
    tick();
    chk("t5_card3", {4'd0, card3}, 8'd11);
    chk("t5_scoreJ", {4'd0, score}, 8'd7);

    // Reset mid-hand with deal high.
    do_clear();
    deal = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    deal = 1'b0;
    chk("t6_card1", {4'd0, card1}, 8'd0);
    chk("t6_card2", {4'd0, card2}, 8'd0);
    chk("t6_score", {4'd0, score}, 8'd0);
    deal = 1'b1;
    tick();
    deal = 1'b0;
    chk("t6_ctr1", {4'd0, card1}, 8'd1);
    tick();

    chk("sb_empty", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/card_hand_dealer.md
Name: card_hand_dealer

Overview:
- Upstream stage of the per-card 7-segment decoder in the baccarat datapath.
- Runs a free-running 1..13 card counter, so the dealt card depends on when the user presses the key.
- On each deal request, latches the current counter value into the next free slot of a 3-card hand.
- Each 4-bit slot feeds one 7-seg card decoder; the block also keeps a registered baccarat score of the hand.

Parameters:
- CARD_MIN, 1, lowest card code produced by the counter (Ace).
- CARD_MAX, 13, highest card code produced by the counter (King); counter wraps from CARD_MAX back to CARD_MIN.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- deal  in  1  deal request, sampled every clk edge; level-sensitive, so each high cycle is one request.
- clear  in  1  empty the hand, sampled every clk edge.
- card1  out  4  first dealt card code (0 = empty slot, 1..13 = A..K).
- card2  out  4  second dealt card code (0 = empty slot).
- card3  out  4  third dealt card code (0 = empty slot).
- count  out  2  number of occupied slots, 0..3.
- full  out  1  high when count == 3.
- deal_ack  out  1  one-cycle pulse the cycle after a deal is accepted.
- score  out  4  hand value mod 10, range 0..9.

Behaviour:
- Reset (rst high at an edge): counter=1, card1..3=0, count=0, full=0, deal_ack=0, score=0.
- rst overrides deal and clear. Reset mid-hand discards all cards.
- Counter, internal 4-bit:
  - Every edge not in reset: if counter==CARD_MAX, counter<=CARD_MIN; else counter<=counter+1.
  - Never holds and never produces 0 or 14/15.
  - First cycle after reset release presents 1, then 2, 3, ... 13, 1, ...
- Deal:
  - Accepted when deal==1, clear==0 and count<3.
  - On acceptance, slot[count] <= counter value present in that same cycle (pre-increment), and count <= count+1.
  - Slot order is card1, card2, card3.
  - deal_ack is 1 in the cycle after acceptance, 0 otherwise.
  - deal high for N consecutive cycles with room gives N accepted deals of consecutive counter values.
- Full:
  - full = (count==3), registered consistently with count.
  - Deal while full is dropped: no slot changes, count stays 3, deal_ack stays 0. This is not an error.
- Clear:
  - card1..3 <= 0, count <= 0, score <= 0 at that edge.
  - clear has priority over a simultaneous deal; that deal is dropped and deal_ack=0.
  - Counter is unaffected by clear.
- Score:
  - Registered, 1-cycle latency after the card registers.
  - At each edge, score <= (v(card1)+v(card2)+v(card3)) mod 10, computed from the current register values.
  - Card values: v(0)=0, v(n)=n for n=1..9, v(10..13)=0.
  - Raw sum max 27 (5-bit); reduce mod 10 by conditional subtraction of 20 or 10.
  - A card latched at edge E is reflected in score from edge E+1.
  - On clear, score is forced to 0 at the same edge as the cards.
- No other state. Outputs are all registered; no combinational path from inputs to outputs.

Test Plan:
- Reset counter check: release rst, then deal at the 5th cycle after release (counter=5) → card1=5, count=1, full=0, deal_ack=1 for exactly one cycle, score=5 one cycle after card1 updates.
- Back-to-back deal, counter wrap: deal held high for 3 cycles starting when counter=12 → card1=12, card2=13, card3=1, count=3, full=1, final score=1 (0+0+1).
- Full drop and clear: with hand full, pulse deal → cards, count and score unchanged, deal_ack=0. Then pulse clear → cards=0, count=0, full=0, score=0 at the same edge.
- Clear/deal collision: clear and deal high in the same cycle with count=1 → count=0, all cards 0, deal_ack=0.
- Score mod 10 and face cards: deal cards 9, 8, 11 → score goes 9, then 7 (17 mod 10), then stays 7 after the Jack.
- Reset mid-hand: rst high for one cycle with count=2 and deal also high → all outputs at reset values; counter presents 1 the next cycle.
